// File: rtl/input_conditioner.sv
// Board-input front end: synchronises raw pad inputs into clk_i, debounces the two
// push-buttons with independent FSMs (level + one-cycle press pulse) and filters the
// slide switches with a tick-sampled two-sample agreement filter.

// Debounce FSM for a single, already-synchronised button level.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   IDLE         | button released and stable, level 0
//   PRESS_WAIT   | sync went high, counting stable high samples, level 0
//   HELD         | press accepted, level 1
//   RELEASE_WAIT | sync went low, counting stable low samples, level 1
module input_conditioner_btn #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sync_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The cycle that enters a wait state is the first stable sample, so the
    // window closes when the incremented count reaches DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state and counter logic; any bounce drops back and restarts the window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_i) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_i) begin
                    state_d = IDLE;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!sync_i) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_i) begin
                    state_d = HELD;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so level and pulse are registered together.
    always_comb begin
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        pulse_d = (state_q == PRESS_WAIT) && (state_d == HELD);
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int NUM_SW          = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              btn_l_raw_i,
    input  logic              btn_r_raw_i,
    input  logic [NUM_SW-1:0] sw_raw_i,
    output logic              btn_l_o,
    output logic              btn_r_o,
    output logic              btn_l_pulse_o,
    output logic              btn_r_pulse_o,
    output logic [NUM_SW-1:0] switch_o
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end

    localparam int RAW_W  = NUM_SW + 2;
    localparam int TICK_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = left button, bit 1 = right button, upper bits = switches.
    logic [RAW_W-1:0]  sync_q [SYNC_STAGES];
    logic [RAW_W-1:0]  sync_last;
    logic [NUM_SW-1:0] sw_sync;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [NUM_SW-1:0] samp_q, samp_d;
    logic [NUM_SW-1:0] switch_q, switch_d;
    logic [NUM_SW-1:0] agree;

    // Synchroniser chain for every raw pad bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {sw_raw_i, btn_r_raw_i, btn_l_raw_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign sw_sync   = sync_last[RAW_W-1:2];

    input_conditioner_btn #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_l (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sync_i  (sync_last[0]),
        .level_o (btn_l_o),
        .pulse_o (btn_l_pulse_o)
    );

    input_conditioner_btn #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_r (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sync_i  (sync_last[1]),
        .level_o (btn_r_o),
        .pulse_o (btn_r_pulse_o)
    );

    assign tick  = (tick_cnt_q == TICK_LAST);
    assign agree = ~(sw_sync ^ samp_q);

    // Switch filter: a bit moves only when two consecutive tick samples agree.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        samp_d     = samp_q;
        switch_d   = switch_q;
        if (tick) begin
            samp_d   = sw_sync;
            switch_d = (sw_sync & agree) | (switch_q & ~agree);
        end
    end

    // Tick counter, sample and debounced switch registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt_q <= '0;
            samp_q     <= '0;
            switch_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            switch_q   <= switch_d;
        end
    end

    assign switch_o = switch_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: directed scenarios plus randomized pad activity,
// every cycle compared against a behavioural model of the debounce rules.
module tb_input_conditioner;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int NSW  = 16;

    logic           clk_sys   = 1'b0;
    logic           rst_n     = 1'b0;
    logic           btn_l_raw = 1'b0;
    logic           btn_r_raw = 1'b0;
    logic [NSW-1:0] sw_raw    = '0;
    logic           btn_l, btn_r, btn_l_pulse, btn_r_pulse;
    logic [NSW-1:0] sw_out;

    always #5 clk_sys = ~clk_sys;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC),
        .NUM_SW          (NSW)
    ) dut (
        .clk_i         (clk_sys),
        .rst_n_i       (rst_n),
        .btn_l_raw_i   (btn_l_raw),
        .btn_r_raw_i   (btn_r_raw),
        .sw_raw_i      (sw_raw),
        .btn_l_o       (btn_l),
        .btn_r_o       (btn_r),
        .btn_l_pulse_o (btn_l_pulse),
        .btn_r_pulse_o (btn_r_pulse),
        .switch_o      (sw_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: pad values delayed SYNC edges; a button level flips after DEB
    // consecutive samples disagreeing with it; switches are sampled every DEB-th edge
    // after reset and a bit follows the sample only when it matches the previous one.
    logic [NSW+1:0] m_pipe [SYNC];
    logic           m_lvl  [2];
    int             m_run  [2];
    logic           m_pls  [2];
    logic [NSW-1:0] m_samp, m_sw;
    int             m_edges;

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 1'b0;
            m_run[b] = 0;
            m_pls[b] = 1'b0;
        end
        m_samp  = '0;
        m_sw    = '0;
        m_edges = 0;
    endtask

    task automatic model_edge();
        logic [NSW+1:0] seen;
        seen = m_pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = {sw_raw, btn_r_raw, btn_l_raw};
        m_edges++;
        for (int b = 0; b < 2; b++) begin
            m_pls[b] = 1'b0;
            if (seen[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = seen[b];
                    m_pls[b] = seen[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        if (m_edges % DEB == 0) begin
            for (int i = 0; i < NSW; i++)
                if (seen[i+2] == m_samp[i]) m_sw[i] = seen[i+2];
            m_samp = seen[NSW+1:2];
        end
    endtask

    // Per-scenario observation of the DUT.
    int             edge_no, first_l, first_r, first_lo_l, pl_l, pl_r, first_sw;
    logic           hi_l, lo_r, sw_bad;
    logic [NSW-1:0] sw_from, sw_to;

    task automatic clear_watch();
        edge_no    = 0;
        first_l    = -1;
        first_r    = -1;
        first_lo_l = -1;
        first_sw   = -1;
        pl_l       = 0;
        pl_r       = 0;
        hi_l       = 1'b0;
        lo_r       = 1'b0;
        sw_bad     = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        edge_no++;
        check_eq("btn_l", 32'(btn_l), 32'(m_lvl[0]));
        check_eq("btn_r", 32'(btn_r), 32'(m_lvl[1]));
        check_eq("btn_l_pulse", 32'(btn_l_pulse), 32'(m_pls[0]));
        check_eq("btn_r_pulse", 32'(btn_r_pulse), 32'(m_pls[1]));
        check_eq("switch", 32'(sw_out), 32'(m_sw));
        if (btn_l_pulse) begin
            pl_l++;
            if (first_l < 0) first_l = edge_no;
        end
        if (btn_r_pulse) begin
            pl_r++;
            if (first_r < 0) first_r = edge_no;
        end
        if (!btn_l && first_lo_l < 0) first_lo_l = edge_no;
        if (btn_l) hi_l = 1'b1;
        if (!btn_r) lo_r = 1'b1;
        if (sw_out == sw_to && first_sw < 0) first_sw = edge_no;
        if (sw_out != sw_from && sw_out != sw_to) sw_bad = 1'b1;
    endtask

    int hold_l, hold_r, hold_sw;

    initial begin
        model_reset();
        sw_from = '0;
        sw_to   = '0;
        clear_watch();
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();

        // Clean press and release.
        btn_l_raw = 1'b1;
        clear_watch();
        repeat (20) cyc();
        check_eq("s1_pulse_edge", 32'(first_l), 32'd6);
        check_eq("s1_pulse_count", 32'(pl_l), 32'd1);
        btn_l_raw = 1'b0;
        clear_watch();
        repeat (12) cyc();
        check_eq("s1_release_edge", 32'(first_lo_l), 32'd6);
        check_eq("s1_release_pulses", 32'(pl_l), 32'd0);

        // Bouncing press: final rise lands before edge 9 of this window.
        clear_watch();
        for (int k = 0; k < 10; k++) begin
            btn_l_raw = ((k / 2) % 2 == 0);
            cyc();
        end
        check_eq("s2_level_during_bounce", 32'(hi_l), 32'd0);
        repeat (14) cyc();
        check_eq("s2_pulse_edge", 32'(first_l), 32'd14);
        check_eq("s2_pulse_count", 32'(pl_l), 32'd1);
        btn_l_raw = 1'b0;
        repeat (10) cyc();

        // Release glitch while held.
        btn_r_raw = 1'b1;
        repeat (10) cyc();
        clear_watch();
        btn_r_raw = 1'b0;
        repeat (2) cyc();
        btn_r_raw = 1'b1;
        repeat (12) cyc();
        check_eq("s3_level_dropped", 32'(lo_r), 32'd0);
        check_eq("s3_extra_pulse", 32'(pl_r), 32'd0);
        btn_r_raw = 1'b0;
        repeat (10) cyc();

        // Switch change, then a one-cycle glitch on bit 0.
        sw_from = '0;
        sw_to   = 16'hA5A5;
        clear_watch();
        sw_raw = 16'hA5A5;
        repeat (12) cyc();
        check_eq("s4_latency_ok", 32'(first_sw >= 1 && first_sw <= 11), 32'd1);
        check_eq("s4_value", 32'(sw_out), 32'hA5A5);
        check_eq("s4_intermediate", 32'(sw_bad), 32'd0);
        sw_from = 16'hA5A5;
        clear_watch();
        sw_raw = 16'hA5A4;
        cyc();
        sw_raw = 16'hA5A5;
        repeat (12) cyc();
        check_eq("s4_glitch_passed", 32'(sw_bad), 32'd0);

        // Simultaneous presses.
        clear_watch();
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        repeat (10) cyc();
        check_eq("s5_l_pulse_edge", 32'(first_l), 32'd6);
        check_eq("s5_r_pulse_edge", 32'(first_r), 32'd6);
        check_eq("s5_pulse_counts", 32'(pl_l + pl_r), 32'd2);
        btn_l_raw = 1'b0;
        repeat (10) cyc();

        // Reset during left PRESS_WAIT while right is held and switches are set.
        btn_l_raw = 1'b1;
        repeat (4) cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("s6_rst_btn_l", 32'(btn_l), 32'd0);
        check_eq("s6_rst_btn_r", 32'(btn_r), 32'd0);
        check_eq("s6_rst_pulses", 32'({btn_l_pulse, btn_r_pulse}), 32'd0);
        check_eq("s6_rst_switch", 32'(sw_out), 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        clear_watch();
        repeat (12) cyc();
        check_eq("s6_l_pulse_edge", 32'(first_l), 32'd6);
        check_eq("s6_l_pulse_count", 32'(pl_l), 32'd1);
        check_eq("s6_r_pulse_edge", 32'(first_r), 32'd6);
        check_eq("s6_r_pulse_count", 32'(pl_r), 32'd1);

        // Randomized pad activity with mixed short bounces and long holds.
        hold_l  = 0;
        hold_r  = 0;
        hold_sw = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold_l == 0) begin
                btn_l_raw = 1'($urandom_range(0, 1));
                hold_l    = $urandom_range(1, 10);
            end
            if (hold_r == 0) begin
                btn_r_raw = 1'($urandom_range(0, 1));
                hold_r    = $urandom_range(1, 10);
            end
            if (hold_sw == 0) begin
                if ($urandom_range(0, 1) == 0) sw_raw = NSW'($urandom);
                else sw_raw[$urandom_range(0, NSW - 1)] ^= 1'b1;
                hold_sw = $urandom_range(1, 14);
            end
            if (c == 700) rst_n = 1'b0;
            if (c == 703) rst_n = 1'b1;
            hold_l--;
            hold_r--;
            hold_sw--;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
